// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI pins, the SPI slave front end and the single-port RAM.
// rx_valid and tx_valid are one-cycle strobes with no backpressure: the consumer must take the value in that cycle.
interface spi_slave_if_if #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
);
  logic            SS_n;
  logic            MOSI;
  logic            MISO;
  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit {cmd,data} frames for the RAM and serialises the RAM read byte onto MISO.
// Debug ports expose the FSM state (IDLE=0, CHK_CMD=1, WRITE=2, READ_ADD=3, READ_DATA=4) and the read-address flag.
module spi_slave_if (
  input  logic          clk,
  input  logic          rst_n,
  spi_slave_if_if.slave bus,
  output logic [2:0]    dbg_state,
  output logic          dbg_rd_addr_seen
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  bit_cnt;
  logic [8:0]  rx_sh;
  logic [6:0]  tx_sh;
  logic [3:0]  miso_cnt;
  logic        rd_addr_seen;
  logic        sample;
  logic        last_bit;
  logic        tx_load;
  logic        tx_shift;

  assign dbg_state        = state;
  assign dbg_rd_addr_seen = rd_addr_seen;

  always_comb begin
    state_next = state;
    sample     = 1'b0;
    last_bit   = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.SS_n) state_next = CHK_CMD;
      end
      CHK_CMD: begin
        if (bus.SS_n)      state_next = IDLE;
        else if (!bus.MOSI) state_next = WRITE;
        else if (rd_addr_seen) state_next = READ_DATA;
        else                state_next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state != IDLE && !bus.SS_n) begin
      sample   = (bit_cnt < 4'd10);
      last_bit = (bit_cnt == 4'd9);
      // The RAM byte is only accepted once the read-data word has been handed over and before any byte was taken.
      tx_load  = (state == READ_DATA) && (bit_cnt == 4'd10) && (miso_cnt == 4'd0) && bus.tx_valid;
      tx_shift = (miso_cnt != 4'd0) && (miso_cnt < 4'd8);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= 4'd0;
      rx_sh        <= 9'd0;
      tx_sh        <= 7'd0;
      miso_cnt     <= 4'd0;
      rd_addr_seen <= 1'b0;
      bus.MISO     <= 1'b0;
      bus.rx_data  <= 10'd0;
      bus.rx_valid <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      if (state == IDLE || bus.SS_n) begin
        bit_cnt  <= 4'd0;
        miso_cnt <= 4'd0;
        tx_sh    <= 7'd0;
        bus.MISO <= 1'b0;
      end else begin
        if (sample) begin
          rx_sh   <= {rx_sh[7:0], bus.MOSI};
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (last_bit) begin
          bus.rx_data  <= {rx_sh, bus.MOSI};
          bus.rx_valid <= 1'b1;
          if (state == READ_ADD)  rd_addr_seen <= 1'b1;
          if (state == READ_DATA) rd_addr_seen <= 1'b0;
        end
        // MISO carries tx_data[7] from the load edge; the remaining seven bits come out of tx_sh MSB first.
        if (tx_load) begin
          tx_sh    <= bus.tx_data[6:0];
          bus.MISO <= bus.tx_data[7];
          miso_cnt <= 4'd1;
        end else if (tx_shift) begin
          tx_sh    <= {tx_sh[5:0], 1'b0};
          bus.MISO <= tx_sh[6];
          miso_cnt <= miso_cnt + 4'd1;
        end else begin
          bus.MISO <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: directed frames followed by random frames, checked against a frame-level model.
module tb_spi_slave_if;

  localparam logic [31:0] IDLE_CODE = 32'd0;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  logic       dbg_seen;

  spi_slave_if_if bus ();

  spi_slave_if dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .dbg_state        (dbg_state),
    .dbg_rd_addr_seen (dbg_seen)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  bit         seen_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rx_valid) begin
      if (exp_q.size() == 0) check("rx_unexpected", 32'(bus.rx_valid), 32'd0);
      else                   check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    step();
    bus.SS_n     = 1'b1;
    bus.tx_valid = 1'b0;
    step();
    check("frame_end_idle", 32'(dbg_state), IDLE_CODE);
    check("frame_end_miso", 32'(bus.MISO), 32'd0);
    check("rd_addr_seen", 32'(dbg_seen), 32'(seen_m));
  endtask

  // nbits < 10 aborts the frame; rst_at >= 0 asserts reset after that many MISO bits of a read-data tail.
  task automatic send_frame(input logic [9:0] f, input int nbits, input logic [7:0] b, input int rst_at);
    bit is_rd;
    is_rd = f[9] && seen_m;
    step();
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom);
    if (nbits == 10) exp_q.push_back(f);
    for (int i = 0; i < nbits; i++) begin
      step();
      check("miso_rx", 32'(bus.MISO), 32'd0);
      bus.MOSI     = f[9-i];
      bus.tx_valid = ($urandom_range(0, 3) == 0);
      bus.tx_data  = 8'($urandom);
    end
    if (nbits < 10) begin
      end_frame();
      return;
    end
    step();
    bus.tx_valid = 1'b0;
    bus.MOSI     = 1'($urandom);
    check("miso_done", 32'(bus.MISO), 32'd0);
    if (f[9]) seen_m = !seen_m;
    if (is_rd) begin
      step();
      check("miso_wait", 32'(bus.MISO), 32'd0);
      bus.tx_valid = 1'b1;
      bus.tx_data  = b;
      for (int k = 0; k < 8; k++) begin
        step();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        if (k == rst_at) begin
          rst_n = 1'b0;
          #1;
          check("rst_miso", 32'(bus.MISO), 32'd0);
          check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
          check("rst_state", 32'(dbg_state), IDLE_CODE);
          check("rst_seen", 32'(dbg_seen), 32'd0);
          seen_m   = 1'b0;
          bus.SS_n = 1'b1;
          step();
          rst_n = 1'b1;
          step();
          return;
        end
        check("miso_bit", 32'(bus.MISO), 32'(b[7-k]));
      end
      step();
      check("miso_tail", 32'(bus.MISO), 32'd0);
    end
    repeat ($urandom_range(0, 2)) begin
      step();
      bus.MOSI     = 1'($urandom);
      bus.tx_valid = 1'($urandom);
      check("miso_extra", 32'(bus.MISO), 32'd0);
    end
    end_frame();
  endtask

  initial begin
    logic [9:0] f;
    int         nb;
    rst_n        = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'd0;
    repeat (3) step();
    check("reset_miso", 32'(bus.MISO), 32'd0);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    check("reset_state", 32'(dbg_state), IDLE_CODE);
    check("reset_seen", 32'(dbg_seen), 32'd0);
    rst_n = 1'b1;
    step();

    send_frame(10'h0A5, 10, 8'h00, -1);   // write address
    send_frame(10'h1F0, 10, 8'h00, -1);   // write data
    send_frame(10'h23C, 10, 8'h00, -1);   // read address
    send_frame(10'h300, 10, 8'h3C, -1);   // read data, byte 3C on MISO
    send_frame(10'h0A5, 5,  8'h00, -1);   // aborted write
    send_frame(10'h155, 10, 8'h00, -1);
    send_frame(10'h2AA, 10, 8'h00, -1);   // read address, then reset during the MISO byte
    send_frame(10'h3FF, 10, 8'hA5, 3);
    send_frame(10'h381, 10, 8'h00, -1);   // must be treated as a read address again

    for (int n = 0; n < 60; n++) begin
      f  = 10'($urandom_range(0, 1023));
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 10;
      send_frame(f, nb, 8'($urandom), -1);
    end

    repeat (3) step();
    check("exp_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
